// File: rtl/video_timing_tx.sv
// VESA-style vs/hs/de timing generator pulling 24-bit pixels from an FWFT source.
// Optional macro TIMING_TX_PATTERN_EN replaces the pixel source with an 8-bar colour pattern.
module video_timing_tx #(
    parameter int          IMG_WIDTH     = 1280,
    parameter int          H_FP          = 110,
    parameter int          H_SYNC        = 40,
    parameter int          H_BP          = 220,
    parameter int          IMG_HEIGHT    = 720,
    parameter int          V_FP          = 5,
    parameter int          V_SYNC        = 5,
    parameter int          V_BP          = 20,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_req,
    output logic        video_vs,
    output logic        video_hs,
    output logic        video_de,
    output logic [23:0] video_data,
    output logic        frame_start,
    output logic        underflow
);

    // state | meaning
    // IDLE  | counters held at 0, no timing or pixel requests
    // RUN   | counters free-run; leaves only on the last clk of a frame
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] H_LAST   = 16'(IMG_WIDTH + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST   = 16'(IMG_HEIGHT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_ACT    = 16'(IMG_WIDTH);
    localparam logic [15:0] V_ACT    = 16'(IMG_HEIGHT);
    localparam logic [15:0] HS_START = 16'(IMG_WIDTH + H_FP);
    localparam logic [15:0] HS_END   = 16'(IMG_WIDTH + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(IMG_HEIGHT + V_FP);
    localparam logic [15:0] VS_END   = 16'(IMG_HEIGHT + V_FP + V_SYNC);

    state_t      state_q, state_d;
    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] v_cnt_q, v_cnt_d;
    logic        vs_q, vs_d;
    logic        hs_q, hs_d;
    logic        de_q, de_d;
    logic [23:0] data_q, data_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d;

    logic        run;
    logic        de_n;
    logic        miss;
    logic [23:0] pix_sel;

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = '0;
                        if (!en) state_d = IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 16'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run  = (state_q == RUN);
    assign de_n = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

`ifdef TIMING_TX_PATTERN_EN
    localparam logic [15:0] BAR_W = 16'(IMG_WIDTH / 8);
    logic [15:0] bar_idx;

    assign bar_idx = h_cnt_q / BAR_W;
    assign pix_req = 1'b0;
    assign miss    = 1'b0;

    always_comb begin
        pix_sel = 24'h000000;
        case (bar_idx[2:0])
            3'd0: pix_sel = 24'hFFFFFF;
            3'd1: pix_sel = 24'hFFFF00;
            3'd2: pix_sel = 24'h00FFFF;
            3'd3: pix_sel = 24'h00FF00;
            3'd4: pix_sel = 24'hFF00FF;
            3'd5: pix_sel = 24'hFF0000;
            3'd6: pix_sel = 24'h0000FF;
            default: pix_sel = 24'h000000;
        endcase
    end
`else
    assign pix_req = de_n;
    assign miss    = de_n && !pix_valid;
    assign pix_sel = pix_valid ? pix_data : UNDERFLOW_RGB;
`endif

    // Set wins over the frame-start clear so a missing first pixel is still flagged.
    always_comb begin
        hs_d          = run && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_d          = run && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        de_d          = de_n;
        data_d        = de_n ? pix_sel : 24'h000000;
        frame_start_d = de_n && (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
        underflow_d   = (frame_start_d ? 1'b0 : underflow_q) | miss;
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            de_q          <= 1'b0;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_q          <= vs_d;
            hs_q          <= hs_d;
            de_q          <= de_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign video_vs    = vs_q;
    assign video_hs    = hs_q;
    assign video_de    = de_q;
    assign video_data  = data_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule
